// File: rtl/scratch_pad_reorder_buf.sv
// scratch_pad_reorder_buf: per-port read-return reorder buffer; optional REORDER_BYPASS_EN sends head responses straight to q
module scratch_pad_reorder_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic [TAG_W-1:0] req_tag,
  output logic             full,
  input  logic             rsp_valid,
  input  logic [TAG_W-1:0] rsp_tag,
  input  logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  input  logic             stall
);
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] alloc, filled;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             out_free, do_alloc, do_rsp, do_pop, do_byp, rel;
  assign out_free = !valid || !stall;
  assign do_alloc = req && !full;
`ifdef REORDER_BYPASS_EN
  assign do_byp   = rsp_valid && rsp_tag == head && alloc[head] && !filled[head] && out_free;
`else
  assign do_byp   = 1'b0;
`endif
  assign do_rsp   = rsp_valid && alloc[rsp_tag] && !filled[rsp_tag] && !do_byp;
  assign do_pop   = filled[head] && out_free;
  assign rel      = do_pop || do_byp;
  assign req_tag  = tail;
  // count never exceeds DEPTH, so its top bit alone marks the full state
  assign full     = count[TAG_W];
  // slot storage is written only by accepted responses and needs no reset
  always_ff @(posedge clk)
    if (do_rsp) mem[rsp_tag] <= rsp_data;
  // slot bookkeeping, pointers and in-order output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      alloc  <= '0;
      filled <= '0;
      q      <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_alloc) begin
        alloc[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (do_rsp) filled[rsp_tag] <= 1'b1;
      if (rel) begin
        alloc[head]  <= 1'b0;
        filled[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      count <= count + {{TAG_W{1'b0}}, do_alloc} - {{TAG_W{1'b0}}, rel};
      if (do_pop) begin
        q     <= mem[head];
        valid <= 1'b1;
      end else if (do_byp) begin
        q     <= rsp_data;
        valid <= 1'b1;
      end else if (!stall) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_scratch_pad_reorder_buf.sv
// tb_scratch_pad_reorder_buf: directed self-checking bench for scratch_pad_reorder_buf (either REORDER_BYPASS_EN build)
module tb_scratch_pad_reorder_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  req_tag;
  logic        full;
  logic        rsp_valid = 1'b0;
  logic [4:0]  rsp_tag = '0;
  logic [15:0] rsp_data = '0;
  logic [15:0] q;
  logic        valid;
  logic        stall = 1'b0;
  int          errors = 0;
  int          checks = 0;
  bit          mon = 1'b0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_w;

  scratch_pad_reorder_buf dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .full(full),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .q(q), .valid(valid), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon && valid) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else exp_w = 16'hxxxx;
      chk("stream", q, exp_w);
    end
  endtask

  task automatic rsp_tick(input logic [4:0] t, input logic [15:0] d);
    rsp_valid = 1'b1;
    rsp_tag = t;
    rsp_data = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 1'b0;
    rsp_valid = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic reqs(input int n);
    req = 1'b1;
    for (int i = 0; i < n; i++) tick();
    req = 1'b0;
  endtask

  initial begin
    // reset held with traffic present
    req = 1'b1;
    rsp_valid = 1'b1;
    rsp_tag = 5'd0;
    rsp_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_q", q, 0);
    chk("rst_tag", req_tag, 0);
    req = 1'b0;
    rsp_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_post_valid", valid, 0);
    chk("rst_post_tag", req_tag, 0);

    // in-order responses
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("io_tag", req_tag, i);
      tick();
    end
    req = 1'b0;
    chk("io_tail", req_tag, 3);
    rsp_tick(5'd0, 16'h000A);
`ifdef REORDER_BYPASS_EN
    chk("io_lat", valid, 1);
    chk("io_q0", q, 16'h000A);
    rsp_tick(5'd1, 16'h000B);
    chk("io_q1", q, 16'h000B);
    rsp_tick(5'd2, 16'h000C);
    chk("io_q2", q, 16'h000C);
`else
    chk("io_lat", valid, 0);
    rsp_tick(5'd1, 16'h000B);
    chk("io_q0", q, 16'h000A);
    rsp_tick(5'd2, 16'h000C);
    chk("io_q1", q, 16'h000B);
    tick();
    chk("io_q2", q, 16'h000C);
`endif
    chk("io_v2", valid, 1);
    tick();
    chk("io_drop", valid, 0);
    chk("io_hold", q, 16'h000C);

    // out-of-order responses
    do_reset();
    reqs(4);
    rsp_tick(5'd3, 16'h0033);
    chk("ooo_wait3", valid, 0);
    rsp_tick(5'd1, 16'h0011);
    chk("ooo_wait1", valid, 0);
    rsp_tick(5'd2, 16'h0022);
    chk("ooo_wait2", valid, 0);
    rsp_tick(5'd0, 16'h0000);
`ifndef REORDER_BYPASS_EN
    chk("ooo_lat", valid, 0);
    tick();
`endif
    chk("ooo_v0", valid, 1);
    chk("ooo_q0", q, 16'h0000);
    tick();
    chk("ooo_q1", q, 16'h0011);
    tick();
    chk("ooo_q2", q, 16'h0022);
    tick();
    chk("ooo_q3", q, 16'h0033);
    chk("ooo_v3", valid, 1);
    tick();
    chk("ooo_end", valid, 0);

    // full
    do_reset();
    req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("full_tag", req_tag, i);
      chk("full_early", full, 0);
      tick();
    end
    chk("full_set", full, 1);
    chk("full_wrap", req_tag, 0);
    tick();
    req = 1'b0;
    chk("full_33_full", full, 1);
    chk("full_33_tag", req_tag, 0);
    rsp_tick(5'd0, 16'h1234);
`ifndef REORDER_BYPASS_EN
    chk("full_fill_full", full, 1);
    chk("full_fill_valid", valid, 0);
    tick();
`endif
    chk("full_clear", full, 0);
    chk("full_pop_valid", valid, 1);
    chk("full_pop_q", q, 16'h1234);
    chk("full_pop_tag", req_tag, 0);
    reqs(1);
    chk("full_re_tag", req_tag, 1);
    chk("full_re_full", full, 1);

    // stall
    do_reset();
    reqs(2);
    stall = 1'b1;
    rsp_tick(5'd0, 16'h0055);
    rsp_tick(5'd1, 16'h0066);
    tick();
    chk("stall_v", valid, 1);
    chk("stall_q", q, 16'h0055);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_v", valid, 1);
      chk("stall_hold_q", q, 16'h0055);
    end
    stall = 1'b0;
    tick();
    chk("stall_next_v", valid, 1);
    chk("stall_next_q", q, 16'h0066);
    tick();
    chk("stall_end", valid, 0);

    // wrap with model stream, then reset mid-operation
    do_reset();
    mon = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req = 1'b1;
      chk("wrap_tag", req_tag, i % 32);
      tick();
      req = 1'b0;
      exp_q.push_back(16'h1000 + 16'(i));
      rsp_tick(5'(i % 32), 16'h1000 + 16'(i));
    end
    tick();
    tick();
    chk("wrap_left", exp_q.size(), 0);
    mon = 1'b0;
    reqs(5);
    chk("wrap_out_tag", req_tag, 13);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_tag", req_tag, 0);
    rsp_tick(5'd3, 16'hDEAD);
    chk("late_rsp_v", valid, 0);
    tick();
    chk("late_rsp_v2", valid, 0);
    mon = 1'b1;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0333);
    reqs(4);
    rsp_tick(5'd3, 16'h0333);
    rsp_tick(5'd0, 16'h0100);
    rsp_tick(5'd1, 16'h0101);
    rsp_tick(5'd2, 16'h0102);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_left", exp_q.size(), 0);
    mon = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
